decodificador_contador_triangular: RTL and testbench

Sequence decoder/checker for the up/down ("triangular") counter output stream. The counter sequence is 0,1,…,15,15,14,…,1,0,0,1,… with a one-sample dwell at each end while the direction flips. The block samples the counter value, locks onto the sequence, recovers the direction, flags turn-arounds, counts full periods and detects sequence violations. It sits on the consumer side of the counter bus, clocked by the same clock.

---
 rtl/decodificador_contador_triangular.sv | 160 ++++++++++++++++
 tb/tb_decodificador_contador_triangular.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decodificador_contador_triangular.sv
// Sequence decoder for the up/down counter stream 0..TOPO,TOPO..0,0..: locks on,
// recovers direction, flags dwells, counts periods and sequence violations.
module decodificador_contador_triangular #(
  parameter int LARGURA        = 4,
  parameter int TRAVA_AMOSTRAS = 4,
  parameter int MAX_ERROS      = 2,
  parameter int LARGURA_PER    = 8,
  parameter int LARGURA_ERR    = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [LARGURA-1:0]     valor,
  input  logic                   valido,
  output logic                   sentido,
  output logic                   travado,
  output logic                   erro,
  output logic                   topo,
  output logic                   base,
  output logic [LARGURA_PER-1:0] periodos,
  output logic [LARGURA_ERR-1:0] erros,
  output logic [1:0]             estado
);

  localparam logic [LARGURA-1:0] TOPO = '1;
  localparam logic [LARGURA-1:0] ZERO = '0;
  localparam logic [LARGURA-1:0] UM   = LARGURA'(1);
  localparam int LM = $clog2(TRAVA_AMOSTRAS + 1);
  localparam int LE = $clog2(MAX_ERROS + 1);

  typedef enum logic [1:0] {DESTRAVADO, PRIMEIRA, ADQUIRINDO, TRAVADO} estado_t;

  estado_t          estado_q;
  logic [LARGURA-1:0] ref_val;
  logic [LARGURA-1:0] pred_v;
  logic             pred_s;
  logic [LM-1:0]    match_cnt;
  logic [LE-1:0]    miss_cnt;

  // Direction encoding: 0 = up, 1 = down.
  function automatic logic [LARGURA-1:0] prox_valor(input logic [LARGURA-1:0] v, input logic s);
    if (!s) return (v == TOPO) ? TOPO : v + UM;
    else    return (v == ZERO) ? ZERO : v - UM;
  endfunction

  function automatic logic prox_sentido(input logic [LARGURA-1:0] v, input logic s);
    if (!s) return (v == TOPO);
    else    return (v != ZERO);
  endfunction

  logic casa, sobe, desce, fica_topo, fica_base, tem_dir, dir_ini;

  always_comb begin
    casa      = (valor == pred_v);
    sobe      = (ref_val != TOPO) && (valor == ref_val + UM);
    desce     = (ref_val != ZERO) && (valor == ref_val - UM);
    fica_topo = (valor == ref_val) && (valor == TOPO);
    fica_base = (valor == ref_val) && (valor == ZERO);
    tem_dir   = sobe | desce | fica_topo | fica_base;
    dir_ini   = desce | fica_topo;
  end

  assign estado = estado_q;

  // valido is a one-way strobe with no back-pressure: every cycle it is high,
  // valor is consumed as exactly one counter step; low cycles are ignored.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q  <= DESTRAVADO;
      ref_val   <= '0;
      pred_v    <= '0;
      pred_s    <= 1'b0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      sentido   <= 1'b0;
      travado   <= 1'b0;
      erro      <= 1'b0;
      topo      <= 1'b0;
      base      <= 1'b0;
      periodos  <= '0;
      erros     <= '0;
    end else begin
      erro <= 1'b0;
      topo <= 1'b0;
      base <= 1'b0;
      if (valido) begin
        case (estado_q)
          DESTRAVADO: begin
            ref_val  <= valor;
            estado_q <= PRIMEIRA;
          end
          PRIMEIRA: begin
            if (tem_dir) begin
              pred_v    <= prox_valor(valor, dir_ini);
              pred_s    <= prox_sentido(valor, dir_ini);
              sentido   <= prox_sentido(valor, dir_ini);
              match_cnt <= LM'(1);
              if (TRAVA_AMOSTRAS == 1) begin
                estado_q <= TRAVADO;
                travado  <= 1'b1;
                miss_cnt <= '0;
              end else begin
                estado_q <= ADQUIRINDO;
              end
            end else begin
              ref_val <= valor;
            end
          end
          ADQUIRINDO: begin
            if (casa) begin
              pred_v    <= prox_valor(pred_v, pred_s);
              pred_s    <= prox_sentido(pred_v, pred_s);
              sentido   <= prox_sentido(pred_v, pred_s);
              match_cnt <= match_cnt + LM'(1);
              if (match_cnt == LM'(TRAVA_AMOSTRAS - 1)) begin
                estado_q <= TRAVADO;
                travado  <= 1'b1;
                miss_cnt <= '0;
              end
            end else begin
              ref_val   <= valor;
              match_cnt <= '0;
              sentido   <= 1'b0;
              estado_q  <= PRIMEIRA;
            end
          end
          TRAVADO: begin
            // Prediction advances from itself even on a miss, absorbing lone glitches.
            pred_v  <= prox_valor(pred_v, pred_s);
            pred_s  <= prox_sentido(pred_v, pred_s);
            sentido <= prox_sentido(pred_v, pred_s);
            if (casa) begin
              miss_cnt <= '0;
              if (pred_v == TOPO && pred_s) topo <= 1'b1;
              if (pred_v == ZERO && !pred_s) begin
                base     <= 1'b1;
                periodos <= periodos + LARGURA_PER'(1);
              end
            end else begin
              erro <= 1'b1;
              if (erros != '1) erros <= erros + LARGURA_ERR'(1);
              if (miss_cnt == LE'(MAX_ERROS - 1)) begin
                estado_q  <= DESTRAVADO;
                travado   <= 1'b0;
                sentido   <= 1'b0;
                pred_v    <= '0;
                pred_s    <= 1'b0;
                miss_cnt  <= '0;
                match_cnt <= '0;
              end else begin
                miss_cnt <= miss_cnt + LE'(1);
              end
            end
          end
          default: estado_q <= DESTRAVADO;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_decodificador_contador_triangular.sv
// Bench for decodificador_contador_triangular: a phase-table model of the
// 32-step triangular sequence predicts every output after each clock.
module tb_decodificador_contador_triangular;

  localparam int W = 21;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] valor;
  logic       valido;
  logic       sentido, travado, erro, topo, base;
  logic [7:0] periodos, erros;
  logic [1:0] estado;
  logic [W-1:0] obs;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_v;

  int n_checks = 0;
  int n_fail   = 0;

  // model state: 0 idle, 1 first sample seen, 2 acquiring, 3 locked
  int         m_st, m_phase, m_match, m_miss;
  logic [3:0] m_ref;
  logic       m_erro, m_topo, m_base;
  logic [7:0] m_periodos, m_erros;

  decodificador_contador_triangular #(
    .LARGURA(4), .TRAVA_AMOSTRAS(4), .MAX_ERROS(2), .LARGURA_PER(8), .LARGURA_ERR(8)
  ) dut (
    .clock(clock), .reset(reset), .valor(valor), .valido(valido),
    .sentido(sentido), .travado(travado), .erro(erro), .topo(topo), .base(base),
    .periodos(periodos), .erros(erros), .estado(estado)
  );

  always #5 clock = ~clock;

  assign obs = {sentido, travado, erro, topo, base, periodos, erros};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Position p of the period: 0..15 rising, 16..31 falling (15 and 0 each appear twice).
  function automatic logic [3:0] seq_at(input int p);
    int q;
    q = p % 32;
    return (q < 16) ? 4'(q) : 4'(31 - q);
  endfunction

  task automatic model_reset();
    m_st = 0; m_phase = 0; m_match = 0; m_miss = 0; m_ref = '0;
    m_erro = 0; m_topo = 0; m_base = 0; m_periodos = '0; m_erros = '0;
  endtask

  task automatic model(input logic [3:0] v, input logic vld);
    int found;
    m_erro = 0; m_topo = 0; m_base = 0;
    if (!vld) return;
    case (m_st)
      0: begin m_ref = v; m_st = 1; end
      1: begin
        found = -1;
        for (int p = 0; p < 32; p++)
          if (seq_at(p + 31) == m_ref && seq_at(p) == v) found = p;
        if (found >= 0) begin
          m_phase = (found + 1) % 32; m_match = 1; m_st = 2;
        end else m_ref = v;
      end
      2: begin
        if (v == seq_at(m_phase)) begin
          m_phase = (m_phase + 1) % 32; m_match++;
          if (m_match == 4) begin m_st = 3; m_miss = 0; end
        end else begin
          m_ref = v; m_match = 0; m_st = 1;
        end
      end
      default: begin
        if (v == seq_at(m_phase)) begin
          m_miss = 0;
          m_topo = (m_phase == 16);
          m_base = (m_phase == 0);
          if (m_base) m_periodos = m_periodos + 8'd1;
        end else begin
          m_erro = 1; m_miss++;
          if (m_erros != 8'hFF) m_erros = m_erros + 8'd1;
        end
        m_phase = (m_phase + 1) % 32;
        if (m_miss == 2) begin m_st = 0; m_miss = 0; m_phase = 0; end
      end
    endcase
  endtask

  task automatic step(input logic [3:0] v, input logic vld);
    logic s;
    valor = v; valido = vld;
    @(posedge clock); #1;
    model(v, vld);
    s = (m_st >= 2) ? (m_phase >= 16) : 1'b0;
    exp_q.push_back({s, (m_st == 3) ? 1'b1 : 1'b0, m_erro, m_topo, m_base, m_periodos, m_erros});
  endtask

  task automatic do_reset();
    valido = 1'b0;
    reset = 1'b0;
    model_reset();
    exp_q.delete();
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; valido = 1'b0; valor = '0;
    model_reset();
    #12;
    n_checks++;
    if (obs !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", obs); end
    n_checks++;
    if (estado !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", estado); end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_lock_ideal();
    do_reset();
    for (int i = 0; i < 33; i++) begin
      step(seq_at(i), 1'b1);
      exp_v = exp_q.pop_front();
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL lock_ideal sample %0d: got %h expected %h", i, obs, exp_v); end
      if (i == 3 || i == 4) begin
        n_checks++;
        if (travado !== (i == 4)) begin n_fail++; $display("FAIL lock_edge sample %0d: travado=%b expected %b", i, travado, i == 4); end
      end
      if (i == 16) begin
        n_checks++;
        if (topo !== 1'b1) begin n_fail++; $display("FAIL topo_dwell: topo=%b expected 1", topo); end
      end
    end
    n_checks++;
    if (base !== 1'b1 || periodos !== 8'd1 || erros !== 8'd0) begin
      n_fail++; $display("FAIL first_period: base=%b periodos=%0d erros=%0d expected 1 1 0", base, periodos, erros);
    end
  endtask

  task automatic test_glitch();
    for (int i = 33; i < 48; i++) begin
      step((i == 39) ? 4'd9 : seq_at(i), 1'b1);
      exp_v = exp_q.pop_front();
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL glitch sample %0d: got %h expected %h", i, obs, exp_v); end
      if (i == 39) begin
        n_checks++;
        if (erro !== 1'b1 || erros !== 8'd1 || travado !== 1'b1) begin
          n_fail++; $display("FAIL glitch_pulse: erro=%b erros=%0d travado=%b expected 1 1 1", erro, erros, travado);
        end
      end
    end
    n_checks++;
    if (erros !== 8'd1 || travado !== 1'b1) begin n_fail++; $display("FAIL glitch_after: erros=%0d travado=%b expected 1 1", erros, travado); end
  endtask

  task automatic test_unlock();
    logic [3:0] stim[$];
    do_reset();
    for (int i = 0; i < 10; i++) stim.push_back(seq_at(i));
    stim.push_back(4'd0); stim.push_back(4'd0);
    for (int i = 14; i >= 10; i--) stim.push_back(4'(i));
    for (int i = 0; i < stim.size(); i++) begin
      step(stim[i], 1'b1);
      exp_v = exp_q.pop_front();
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL unlock sample %0d: got %h expected %h", i, obs, exp_v); end
      if (i == 11) begin
        n_checks++;
        if (travado !== 1'b0 || erros !== 8'd2 || erro !== 1'b1) begin
          n_fail++; $display("FAIL unlock_drop: travado=%b erros=%0d erro=%b expected 0 2 1", travado, erros, erro);
        end
      end
    end
    n_checks++;
    if (travado !== 1'b1 || sentido !== 1'b1) begin n_fail++; $display("FAIL relock_down: travado=%b sentido=%b expected 1 1", travado, sentido); end
  endtask

  task automatic test_mid_descent();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(seq_at(15 + i), 1'b1);
      exp_v = exp_q.pop_front();
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL mid_descent sample %0d: got %h expected %h", i, obs, exp_v); end
      if (i == 1) begin
        n_checks++;
        if (sentido !== 1'b1 || travado !== 1'b0) begin n_fail++; $display("FAIL top_dwell_dir: sentido=%b travado=%b expected 1 0", sentido, travado); end
      end
      if (i == 4) begin
        n_checks++;
        if (travado !== 1'b1) begin n_fail++; $display("FAIL mid_descent_lock: travado=%b expected 1", travado); end
      end
    end
  endtask

  task automatic test_valid_toggle();
    int k;
    do_reset();
    k = 0;
    for (int c = 0; c < 99; c++) begin
      if (c % 3 == 0) begin
        step(seq_at(k), 1'b1);
        k++;
      end else begin
        step(4'($urandom_range(0, 15)), 1'b0);
      end
      exp_v = exp_q.pop_front();
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL valid_toggle cycle %0d: got %h expected %h", c, obs, exp_v); end
      if (c % 3 != 0) begin
        n_checks++;
        if ({erro, topo, base} !== 3'b000) begin n_fail++; $display("FAIL idle_pulses cycle %0d: got %b expected 000", c, {erro, topo, base}); end
      end
    end
    n_checks++;
    if (periodos !== 8'd1 || travado !== 1'b1) begin n_fail++; $display("FAIL toggle_period: periodos=%0d travado=%b expected 1 1", periodos, travado); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 107; i++) begin
      step((i == 40 || i == 70) ? seq_at(i) + 4'd5 : seq_at(i), 1'b1);
      exp_v = exp_q.pop_front();
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL pre_reset sample %0d: got %h expected %h", i, obs, exp_v); end
    end
    n_checks++;
    if (periodos !== 8'd3 || erros !== 8'd2) begin n_fail++; $display("FAIL pre_reset_counts: periodos=%0d erros=%0d expected 3 2", periodos, erros); end
    valido = 1'b1;
    #3;
    reset = 1'b0;
    #1;
    n_checks++;
    if (obs !== '0 || estado !== 2'd0) begin n_fail++; $display("FAIL async_reset: got %h state %0d expected 0 0", obs, estado); end
    valido = 1'b0;
    model_reset();
    exp_q.delete();
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step(seq_at(i + 3), 1'b1);
      exp_v = exp_q.pop_front();
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL reacquire sample %0d: got %h expected %h", i, obs, exp_v); end
    end
    n_checks++;
    if (travado !== 1'b1) begin n_fail++; $display("FAIL reacquire_lock: travado=%b expected 1", travado); end
  endtask

  task automatic test_random();
    int pos;
    logic vld;
    logic [3:0] v;
    do_reset();
    pos = $urandom_range(0, 31);
    for (int c = 0; c < 600; c++) begin
      vld = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 149) == 0) pos = $urandom_range(0, 31);
      v = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(0, 15)) : seq_at(pos);
      if (vld) pos++;
      step(v, vld);
      exp_v = exp_q.pop_front();
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL random cycle %0d: got %h expected %h", c, obs, exp_v); end
    end
  endtask

  initial begin
    valor = '0;
    valido = 1'b0;
    test_reset();
    test_lock_ideal();
    test_glitch();
    test_unlock();
    test_mid_descent();
    test_valid_toggle();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
